rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Circular reorder buffer; the issue/commit/operand-lookup side of the register-rename interface that the register file consumes.
- Allocates ROB ids at issue and drives new_reg_id/new_ROB_id to the register file.
- Captures CDB results and answers the register file's rs1/rs2 ROB-id lookups with ready/value.
- Commits in order, drives write_reg_id/write_ROB_id/write_val, and raises clear_flag on a mispredicted branch commit.

Parameters:
ROB_WIDTH_BIT, 3, log2 of entry count (8 entries); ids are ROB_WIDTH_BIT wide
RESET_PC, 32'h0, unused by state; redirect_pc value after reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  pause when low
issue_valid  input  1  decoder presents an instruction this cycle
issue_rd  input  5  destination register; 0 = none
issue_is_br  input  1  entry is a conditional branch
issue_pred_taken  input  1  predictor's direction
issue_alt_pc  input  32  PC to fetch if the prediction proves wrong
full  output  1  no free entry; the decoder must not issue
issue_rob_id  output  ROB_WIDTH_BIT  id the next issued entry receives (tail)
new_reg_id  output  5  rename update to the register file
new_ROB_id  output  ROB_WIDTH_BIT  ROB id paired with new_reg_id
wb_valid  input  1  CDB result valid
wb_rob_id  input  ROB_WIDTH_BIT  entry being completed
wb_val  input  32  result value
wb_taken  input  1  actual branch direction (branch entries only)
rs1_id  input  ROB_WIDTH_BIT  lookup id from the register file
rs1_ready  output  1  entry rs1_id holds a value
rs1_val  output  32  value for rs1_id
rs2_id  input  ROB_WIDTH_BIT  as rs1
rs2_ready  output  1  as rs1
rs2_val  output  32  as rs1
write_reg_id  output  5  commit destination; 0 = no write
write_ROB_id  output  ROB_WIDTH_BIT  id of the committing entry
write_val  output  32  committed value
clear_flag  output  1  one-cycle flush pulse
redirect_pc  output  32  correct PC, valid while clear_flag=1

Behaviour:
- Reset (asynchronous): head=tail=count=0; all entry valid/ready bits=0; clear_flag=0; redirect_pc=RESET_PC. Combinational outputs follow from this state: write_*=0, new_*=0, full=0, rs*_ready=0.
- Per entry state: valid, ready, rd, is_br, pred_taken, actual_taken, alt_pc, val.
- full = (count == 2^ROB_WIDTH_BIT). It is computed from registered count only; a same-cycle commit does not free a slot for issue.
- Issue is accepted when issue_valid && !full && rdy_in && !clear_flag.
  - On accept, the tail entry is written with valid=1, ready=0 and the issue fields; tail increments and wraps mod 2^ROB_WIDTH_BIT.
  - new_reg_id = accept ? issue_rd : 0 (combinational). new_ROB_id = tail.
- Writeback: when wb_valid && rdy_in && !clear_flag and entry wb_rob_id is valid, that entry's ready=1, val=wb_val and actual_taken=wb_taken. A writeback to an invalid entry is ignored.
- Lookup (combinational, per port):
  - ready = entry.ready || (wb_valid && wb_rob_id==id).
  - val = CDB bypass when wb_rob_id matches, otherwise entry.val.
  - ready=0 when the entry is invalid.
- Commit happens when the head is valid && ready && rdy_in && !clear_flag. At most one entry commits per cycle.
  - write_reg_id = head.rd, write_ROB_id = head, write_val = head.val, all combinational in the commit cycle. Otherwise all three are 0.
  - On the clock edge the head entry is invalidated and head increments with wrap.
  - count += accept − commit.
- Mispredict: a committing branch with actual_taken != pred_taken latches clear_flag<=1 and redirect_pc<=alt_pc on that edge. The branch's own write_reg_id is 0 because branches have rd=0.
- Flush cycle (clear_flag=1): no issue, writeback or commit is accepted.
  - On this edge all valid bits clear and head=tail=count=0; clear_flag then returns to 0.
  - A subsequent non-mispredict cycle leaves clear_flag=0.
- rdy_in low: all registers hold, and new_reg_id/write_reg_id are forced to 0. Lookups stay live.
- Simultaneous issue and commit when count=2^N−1: both are accepted and count is unchanged.
- Writeback and commit of the same head entry in one cycle: commit waits for the registered ready, so the commit occurs the next cycle.

Test Plan:
- Reset mid-run: assert rst_in asynchronously with 3 entries live -> head=tail=0, full=0 and write_reg_id=0 before the next clk edge.
- Issue rd=5, then rd=6 -> new_reg_id=5/new_ROB_id=0, then 6/1. CDB id1=0x22 then id0=0x11 -> commits in the order reg5=0x11, then reg6=0x22 on consecutive cycles.
- Issue 8 entries -> full=1 and the 9th issue_valid is ignored (tail stays 0). Commit one -> full=0 the next cycle; tail wraps 7->0.
- Lookup: rs1_id=2 while wb_valid with wb_rob_id=2, wb_val=0xABCD -> rs1_ready=1 and rs1_val=0xABCD in the same cycle. An invalid entry -> rs1_ready=0.
- Branch pred_taken=1, alt_pc=0x1040, wb_taken=0 at head -> clear_flag=1 and redirect_pc=0x1040 for exactly one cycle; count=0 afterwards, and the issue during clear is dropped.
- rdy_in=0 for 3 cycles with a ready head -> no commit (write_reg_id=0) and state is unchanged; commit resumes on the first cycle rdy_in=1.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Circular reorder buffer: allocates ids at issue, captures CDB results, answers
// register-file operand lookups and retires entries in order, flushing on a mispredicted branch.
module rob_commit_unit #(
  parameter int          ROB_WIDTH_BIT = 3,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_is_br,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic                     full,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic [4:0]               new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic                     wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [31:0]              wb_val,
  input  logic                     wb_taken,
  input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
  output logic                     rs1_ready,
  output logic [31:0]              rs1_val,
  input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
  output logic                     rs2_ready,
  output logic [31:0]              rs2_val,
  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  output logic                     clear_flag,
  output logic [31:0]              redirect_pc
);

  localparam int DEPTH = 1 << ROB_WIDTH_BIT;
  localparam logic [ROB_WIDTH_BIT:0] FULL_CNT = {1'b1, {ROB_WIDTH_BIT{1'b0}}};

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         ready_q;
  logic [DEPTH-1:0]         is_br_q;
  logic [DEPTH-1:0]         pred_q;
  logic [DEPTH-1:0]         actual_q;
  logic [4:0]               rd_q     [DEPTH];
  logic [31:0]              alt_pc_q [DEPTH];
  logic [31:0]              val_q    [DEPTH];
  logic [ROB_WIDTH_BIT-1:0] head_q;
  logic [ROB_WIDTH_BIT-1:0] tail_q;
  logic [ROB_WIDTH_BIT:0]   count_q;

  logic accept;
  logic wb_en;
  logic commit;
  logic mispredict;

  // Handshakes: an issue is taken when issue_valid && !full (with rdy_in high and no flush
  // pending); the decoder must hold it otherwise. Writebacks are fire-and-forget and dropped
  // for invalid ids. An entry retires only once its registered ready bit is set.
  always_comb begin
    full       = (count_q == FULL_CNT);
    accept     = issue_valid && !full && rdy_in && !clear_flag;
    wb_en      = wb_valid && rdy_in && !clear_flag && valid_q[wb_rob_id];
    commit     = valid_q[head_q] && ready_q[head_q] && rdy_in && !clear_flag;
    mispredict = commit && is_br_q[head_q] && (actual_q[head_q] != pred_q[head_q]);
  end

  always_comb begin
    issue_rob_id = tail_q;
    new_ROB_id   = tail_q;
    new_reg_id   = accept ? issue_rd : 5'd0;
    write_reg_id = 5'd0;
    write_ROB_id = '0;
    write_val    = 32'h0;
    if (commit) begin
      write_reg_id = rd_q[head_q];
      write_ROB_id = head_q;
      write_val    = val_q[head_q];
    end
  end

  // Lookups bypass the CDB so a consumer sees a result in the cycle it is broadcast.
  always_comb begin
    rs1_ready = valid_q[rs1_id] && (ready_q[rs1_id] || (wb_valid && wb_rob_id == rs1_id));
    rs1_val   = (wb_valid && wb_rob_id == rs1_id) ? wb_val : val_q[rs1_id];
    rs2_ready = valid_q[rs2_id] && (ready_q[rs2_id] || (wb_valid && wb_rob_id == rs2_id));
    rs2_val   = (wb_valid && wb_rob_id == rs2_id) ? wb_val : val_q[rs2_id];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      ready_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      clear_flag  <= 1'b0;
      redirect_pc <= RESET_PC;
    end else if (rdy_in) begin
      if (clear_flag) begin
        valid_q    <= '0;
        ready_q    <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        clear_flag <= 1'b0;
      end else begin
        clear_flag <= mispredict;
        if (mispredict) redirect_pc <= alt_pc_q[head_q];
        if (accept) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tail_q + 1'b1;
        end
        if (wb_en) ready_q[wb_rob_id] <= 1'b1;
        if (commit) begin
          valid_q[head_q] <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        count_q <= count_q + {{ROB_WIDTH_BIT{1'b0}}, accept}
                           - {{ROB_WIDTH_BIT{1'b0}}, commit};
      end
    end
  end

  // Payload fields carry no reset: they are only observed behind valid/ready/commit.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      rd_q[tail_q]     <= issue_rd;
      is_br_q[tail_q]  <= issue_is_br;
      pred_q[tail_q]   <= issue_pred_taken;
      alt_pc_q[tail_q] <= issue_alt_pc;
    end
    if (wb_en) begin
      val_q[wb_rob_id]    <= wb_val;
      actual_q[wb_rob_id] <= wb_taken;
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: expected commits are queued at issue and a
// negedge monitor pops and compares them whenever the DUT retires a register write.
module tb_rob_commit_unit;

  localparam int RW = 3;
  localparam int W  = 5 + RW + 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_is_br;
  logic          issue_pred_taken;
  logic [31:0]   issue_alt_pc;
  logic          full;
  logic [RW-1:0] issue_rob_id;
  logic [4:0]    new_reg_id;
  logic [RW-1:0] new_ROB_id;
  logic          wb_valid;
  logic [RW-1:0] wb_rob_id;
  logic [31:0]   wb_val;
  logic          wb_taken;
  logic [RW-1:0] rs1_id;
  logic          rs1_ready;
  logic [31:0]   rs1_val;
  logic [RW-1:0] rs2_id;
  logic          rs2_ready;
  logic [31:0]   rs2_val;
  logic [4:0]    write_reg_id;
  logic [RW-1:0] write_ROB_id;
  logic [31:0]   write_val;
  logic          clear_flag;
  logic [31:0]   redirect_pc;

  rob_commit_unit #(.ROB_WIDTH_BIT(RW), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .full(full), .issue_rob_id(issue_rob_id), .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val), .wb_taken(wb_taken),
    .rs1_id(rs1_id), .rs1_ready(rs1_ready), .rs1_val(rs1_val),
    .rs2_id(rs2_id), .rs2_ready(rs2_ready), .rs2_val(rs2_val),
    .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id), .write_val(write_val),
    .clear_flag(clear_flag), .redirect_pc(redirect_pc)
  );

  // Clock and watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  logic [31:0]  full_vals [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic expect_commit(input logic [4:0] rd, input logic [RW-1:0] id, input logic [31:0] val);
    exp_q.push_back({rd, id, val});
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_is_br = 1'b0;
    issue_pred_taken = 1'b0; issue_alt_pc = 32'h0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_val = 32'h0; wb_taken = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic br, input logic pt, input logic [31:0] alt);
    issue_valid = 1'b1; issue_rd = rd; issue_is_br = br;
    issue_pred_taken = pt; issue_alt_pc = alt;
  endtask

  task automatic drive_wb(input logic [RW-1:0] id, input logic [31:0] val, input logic taken);
    wb_valid = 1'b1; wb_rob_id = id; wb_val = val; wb_taken = taken;
  endtask

  // Monitor: every retiring register write must match the head of the expected queue
  always @(negedge clk_in) begin
    if (!rst_in && write_reg_id != 5'd0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_commit: got reg %0d id %0d val %h required no commit",
                 write_reg_id, write_ROB_id, write_val);
      end else begin
        mon_got = {write_reg_id, write_ROB_id, write_val};
        mon_exp = exp_q.pop_front();
        if (mon_got === mon_exp) n_pass++;
        else $display("FAIL commit: got reg %0d id %0d val %h required reg %0d id %0d val %h",
                      mon_got[W-1 -: 5], mon_got[32 +: RW], mon_got[31:0],
                      mon_exp[W-1 -: 5], mon_exp[32 +: RW], mon_exp[31:0]);
      end
    end
  end

  // Stimulus
  initial begin
    full_vals = '{32'h100, 32'h101, 32'hABCD, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
    rst_in = 1'b1; rdy_in = 1'b1; rs1_id = '0; rs2_id = '0;
    idle_inputs();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_full", full, 0);
    check("rst_tail", issue_rob_id, 0);
    check("rst_write_reg", write_reg_id, 0);
    check("rst_new_reg", new_reg_id, 0);
    check("rst_clear", clear_flag, 0);
    check("rst_redirect", redirect_pc, 32'h0);
    check("rst_rs1_ready", rs1_ready, 0);
    rst_in = 1'b0;

    // In-order commit of out-of-order results
    drive_issue(5'd5, 1'b0, 1'b0, 32'h0); expect_commit(5'd5, 3'd0, 32'h11);
    @(negedge clk_in); check("issue0_reg", new_reg_id, 5); check("issue0_id", new_ROB_id, 0);
    cyc();
    drive_issue(5'd6, 1'b0, 1'b0, 32'h0); expect_commit(5'd6, 3'd1, 32'h22);
    @(negedge clk_in); check("issue1_reg", new_reg_id, 6); check("issue1_id", new_ROB_id, 1);
    cyc();
    idle_inputs(); drive_wb(3'd1, 32'h22, 1'b0); rs1_id = 3'd1;
    @(negedge clk_in); check("bypass_id1_ready", rs1_ready, 1); check("head_not_ready", write_reg_id, 0);
    cyc();
    drive_wb(3'd0, 32'h11, 1'b0); cyc();
    idle_inputs();
    @(negedge clk_in); check("commit_first", write_reg_id, 5);
    cyc();
    @(negedge clk_in); check("commit_second", write_reg_id, 6);
    cyc();

    // Asynchronous reset with three live entries (ids 2..4), head ready
    drive_issue(5'd7, 1'b0, 1'b0, 32'h0); cyc();
    drive_issue(5'd8, 1'b0, 1'b0, 32'h0); cyc();
    drive_issue(5'd9, 1'b0, 1'b0, 32'h0); cyc();
    idle_inputs(); drive_wb(3'd2, 32'h77, 1'b0); rs1_id = 3'd2; cyc();
    idle_inputs();
    #1;
    check("pre_reset_commit", write_reg_id, 7);
    check("pre_reset_rs1_ready", rs1_ready, 1);
    rst_in = 1'b1;
    #1;
    check("async_rst_tail", issue_rob_id, 0);
    check("async_rst_full", full, 0);
    check("async_rst_write_reg", write_reg_id, 0);
    check("async_rst_rs1_ready", rs1_ready, 0);
    cyc();
    rst_in = 1'b0;

    // Fill all eight entries, then a ninth attempt must be ignored
    for (int i = 0; i < 8; i++) begin
      drive_issue(5'(10 + i), 1'b0, 1'b0, 32'h0);
      expect_commit(5'(10 + i), 3'(i), full_vals[i]);
      cyc();
    end
    drive_issue(5'd20, 1'b0, 1'b0, 32'h0);
    @(negedge clk_in);
    check("full_set", full, 1); check("full_no_issue", new_reg_id, 0); check("full_tail", issue_rob_id, 0);
    cyc();
    idle_inputs(); drive_wb(3'd0, full_vals[0], 1'b0);
    @(negedge clk_in); check("full_tail_hold", issue_rob_id, 0);
    cyc();
    idle_inputs(); drive_issue(5'd20, 1'b0, 1'b0, 32'h0);
    @(negedge clk_in);
    check("commit_cycle_still_full", full, 1); check("commit_cycle_no_issue", new_reg_id, 0);
    cyc();
    expect_commit(5'd20, 3'd0, 32'h200);
    @(negedge clk_in);
    check("freed_full", full, 0); check("wrap_issue_reg", new_reg_id, 20); check("wrap_issue_id", new_ROB_id, 0);
    cyc();

    // Drain with lookups on entry 2
    idle_inputs(); rs1_id = 3'd2; rs2_id = 3'd2;
    for (int i = 1; i < 8; i++) begin
      drive_wb(3'(i), full_vals[i], 1'b0);
      @(negedge clk_in);
      if (i == 1) check("lookup_not_ready", rs1_ready, 0);
      if (i == 2) begin
        check("lookup_bypass_ready", rs1_ready, 1);
        check("lookup_bypass_val", rs1_val, 32'hABCD);
        check("lookup_rs2_val", rs2_val, 32'hABCD);
      end
      cyc();
    end
    drive_wb(3'd0, 32'h200, 1'b0); cyc();
    idle_inputs();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) cyc();
    check("drain_empty", exp_q.size(), 0);
    rs1_id = 3'd5;
    @(negedge clk_in); check("lookup_invalid", rs1_ready, 0);
    cyc();

    // rdy_in low for three cycles with a ready head (id 1)
    drive_issue(5'd3, 1'b0, 1'b0, 32'h0); expect_commit(5'd3, 3'd1, 32'h33); cyc();
    idle_inputs(); drive_wb(3'd1, 32'h33, 1'b0); cyc();
    idle_inputs(); rdy_in = 1'b0; drive_issue(5'd9, 1'b0, 1'b0, 32'h0); rs1_id = 3'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("paused_write_reg", write_reg_id, 0);
      check("paused_new_reg", new_reg_id, 0);
      check("paused_tail", issue_rob_id, 2);
      check("paused_lookup", rs1_ready, 1);
      cyc();
    end
    rdy_in = 1'b1; idle_inputs();
    @(negedge clk_in); check("resume_commit", write_reg_id, 3);
    cyc();

    // Mispredicted branch at id 2 followed by a younger entry at id 3
    drive_issue(5'd0, 1'b1, 1'b1, 32'h1040); cyc();
    drive_issue(5'd4, 1'b0, 1'b0, 32'h0); cyc();
    idle_inputs(); drive_wb(3'd2, 32'h0, 1'b0); cyc();
    idle_inputs();
    @(negedge clk_in);
    check("br_commit_id", write_ROB_id, 2); check("br_write_reg", write_reg_id, 0);
    check("br_clear_not_yet", clear_flag, 0);
    cyc();
    drive_issue(5'd12, 1'b0, 1'b0, 32'h0); drive_wb(3'd3, 32'h44, 1'b0);
    @(negedge clk_in);
    check("flush_clear", clear_flag, 1); check("flush_redirect", redirect_pc, 32'h1040);
    check("flush_no_issue", new_reg_id, 0); check("flush_no_commit", write_reg_id, 0);
    cyc();
    idle_inputs(); rs1_id = 3'd3;
    @(negedge clk_in);
    check("post_flush_clear", clear_flag, 0); check("post_flush_tail", issue_rob_id, 0);
    check("post_flush_full", full, 0); check("post_flush_rs1", rs1_ready, 0);
    cyc();
    drive_issue(5'd21, 1'b0, 1'b0, 32'h0); expect_commit(5'd21, 3'd0, 32'h55);
    @(negedge clk_in); check("post_flush_issue_id", new_ROB_id, 0);
    cyc();
    idle_inputs(); drive_wb(3'd0, 32'h55, 1'b0); cyc();
    idle_inputs();
    @(negedge clk_in); check("post_flush_commit", write_reg_id, 21); check("no_spurious_clear", clear_flag, 0);
    cyc();
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cyc();
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
